// File: rtl/seq_det_sched_pkg.sv
// ============================================================================
//  Module : seq_det_sched_pkg
//  Brief  : Shared FSM state encoding and default sizing for seq_det_sched.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_det_sched_pkg;

   localparam int C_NUM_REQ_DEF   = 4;
   localparam int C_FRAME_LEN_DEF = 16;
   localparam int C_DET_LAT_DEF   = 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FLUSH  = 2'd1,
      S_STREAM = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module : rr_arbiter
//  Brief  : Combinational round-robin pick starting one past the last winner.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   always_comb begin : p_search
      int k;
      k     = 0;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      // Offsets 1..NUM_REQ visit every index once, last winner considered last.
      for (int off = 1; off <= NUM_REQ; off++) begin
         k = (int'(i_last) + off) % NUM_REQ;
         if (!o_any && i_req[IDX_W'(k)]) begin
            o_any              = 1'b1;
            o_gnt[IDX_W'(k)]   = 1'b1;
            o_idx              = IDX_W'(k);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_det_sched.sv
// ============================================================================
//  Module : seq_det_sched
//  Brief  : Time-shares one serial sequence detector among NUM_REQ sources.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_det_sched
   import seq_det_sched_pkg::*;
#(
   parameter int NUM_REQ   = C_NUM_REQ_DEF,
   parameter int FRAME_LEN = C_FRAME_LEN_DEF,
   parameter int DET_LAT   = C_DET_LAT_DEF
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] bit_in,
   output logic [NUM_REQ-1:0] grant,
   output logic [NUM_REQ-1:0] bit_ack,
   output logic               det_reset,
   output logic               det_data_in,
   input  logic               det_data_out,
   output logic [NUM_REQ-1:0] match,
   output logic [NUM_REQ-1:0] frame_done
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [NUM_REQ-1:0]   r_grant;
   logic [IDX_W-1:0]     r_owner;
   logic [IDX_W-1:0]     r_last;
   logic [7:0]           r_cnt;
   logic                 r_rst_d;
   logic [DET_LAT-1:0]   r_vld;
   logic [IDX_W-1:0]     r_tag [DET_LAT];
   logic [NUM_REQ-1:0]   w_arb_gnt;
   logic [IDX_W-1:0]     w_arb_idx;
   logic                 w_arb_any;
   logic                 w_last_bit;
   logic                 w_last_drain;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .i_req  (req),
      .i_last (r_last),
      .o_gnt  (w_arb_gnt),
      .o_idx  (w_arb_idx),
      .o_any  (w_arb_any)
   );

   assign w_last_bit   = (r_cnt == 8'(FRAME_LEN - 1));
   assign w_last_drain = (r_cnt == 8'(DET_LAT - 1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_arb_any)    w_state_nxt = S_FLUSH;
         S_FLUSH:                    w_state_nxt = S_STREAM;
         S_STREAM: if (w_last_bit)   w_state_nxt = S_DRAIN;
         S_DRAIN:  if (w_last_drain) w_state_nxt = S_IDLE;
         default:                    w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_owner <= '0;
         r_last  <= IDX_W'(NUM_REQ - 1);
         r_cnt   <= '0;
         r_rst_d <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_rst_d <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_arb_any) begin
                  r_grant <= w_arb_gnt;
                  r_owner <= w_arb_idx;
                  r_last  <= w_arb_idx;
               end
            end
            S_STREAM: r_cnt <= w_last_bit ? 8'd0 : r_cnt + 8'd1;
            S_DRAIN: begin
               r_cnt <= w_last_drain ? 8'd0 : r_cnt + 8'd1;
               if (w_last_drain) r_grant <= '0;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   // Owner tag rides alongside each streamed bit so late detector hits route correctly.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld <= '0;
         for (int i = 0; i < DET_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_vld[0] <= (r_state == S_STREAM);
         r_tag[0] <= r_owner;
         for (int i = 1; i < DET_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   assign grant       = r_grant;
   assign bit_ack     = (r_state == S_STREAM) ? r_grant : '0;
   assign det_data_in = (r_state == S_STREAM) ? bit_in[r_owner] : 1'b0;
   assign det_reset   = reset | r_rst_d | (r_state == S_FLUSH);
   assign frame_done  = (r_state == S_DRAIN && w_last_drain) ? r_grant : '0;
   assign match       = (r_vld[DET_LAT-1] && det_data_out) ?
                        (NUM_REQ'(1) << r_tag[DET_LAT-1]) : '0;

endmodule

`default_nettype wire

// File: tb/tb_seq_det_sched.sv
// ============================================================================
//  Module : tb_seq_det_sched
//  Brief  : Directed self-checking bench for seq_det_sched (default sizing).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_det_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] bit_in;
   logic [3:0] grant;
   logic [3:0] bit_ack;
   logic       det_reset;
   logic       det_data_in;
   logic       det_data_out;
   logic [3:0] match;
   logic [3:0] frame_done;

   int         checks = 0;
   int         errors = 0;
   int         ptr [4];
   logic [3:0] ack_prev;
   logic [3:0] pat = 4'b1101;   // bit sequence 1,0,1,1 indexed 0..3

   seq_det_sched #(
      .NUM_REQ   (4),
      .FRAME_LEN (16),
      .DET_LAT   (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .bit_in       (bit_in),
      .grant        (grant),
      .bit_ack      (bit_ack),
      .det_reset    (det_reset),
      .det_data_in  (det_data_in),
      .det_data_out (det_data_out),
      .match        (match),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   // One clock; sources advance on the ack seen before the edge.
   task automatic cyc();
      ack_prev = bit_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (ack_prev[i]) ptr[i] = ptr[i] + 1;
         bit_in[i] = pat[ptr[i] % 4];
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_frame(input logic [3:0] exp, input int drop_at);
      int n_ack;
      n_ack = 0;
      cyc();
      chk("rr_grant", grant, exp);
      chk("rr_flush_det_reset", det_reset, 1);
      for (int k = 0; k < 16; k++) begin
         cyc();
         if (bit_ack == exp) n_ack++;
         if (k == drop_at) req = 4'b0000;
      end
      chk("rr_ack_count", n_ack, 16);
      cyc();
      chk("rr_frame_done", frame_done, exp);
      chk("rr_drain_ack", bit_ack, 0);
      cyc();
      chk("rr_idle_grant", grant, 0);
   endtask

   initial begin
      reset        = 1'b1;
      req          = 4'b0000;
      det_data_out = 1'b0;
      bit_in       = 4'b1111;
      for (int i = 0; i < 4; i++) ptr[i] = 0;
      cyc();
      cyc();
      chk("rst_grant", grant, 0);
      chk("rst_bit_ack", bit_ack, 0);
      chk("rst_match", match, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_det_data_in", det_data_in, 0);
      chk("rst_det_reset", det_reset, 1);

      reset = 1'b0;
      cyc();
      chk("idle_det_reset", det_reset, 0);
      chk("idle_grant", grant, 0);

      // Single source, detector output held high across IDLE and FLUSH.
      det_data_out = 1'b1;
      cyc();
      chk("idle_match_blocked", match, 0);
      req = 4'b0001;
      cyc();
      chk("s1_grant", grant, 4'b0001);
      chk("s1_flush_det_reset", det_reset, 1);
      chk("s1_flush_match_blocked", match, 0);
      chk("s1_flush_ack", bit_ack, 0);
      for (int k = 0; k < 16; k++) begin
         cyc();
         det_data_out = (k == 0 || k == 5);
         #1;
         chk("s1_bit_ack", bit_ack, 4'b0001);
         chk("s1_det_data_in", det_data_in, pat[k % 4]);
         chk("s1_match", match, (k == 5) ? 4'b0001 : 4'b0000);
      end
      req = 4'b0000;
      cyc();
      det_data_out = 1'b1;
      #1;
      chk("s1_drain_frame_done", frame_done, 4'b0001);
      chk("s1_drain_match", match, 4'b0001);
      chk("s1_drain_ack", bit_ack, 0);
      chk("s1_drain_data_in", det_data_in, 0);
      cyc();
      chk("s1_idle_grant", grant, 0);
      chk("s1_idle_match", match, 0);
      chk("s1_idle_frame_done", frame_done, 0);

      // Reset mid-stream aborts the frame.
      det_data_out = 1'b0;
      req = 4'b0100;
      cyc();
      chk("ab_grant", grant, 4'b0100);
      for (int k = 0; k < 8; k++) cyc();
      chk("ab_bit7_ack", bit_ack, 4'b0100);
      reset        = 1'b1;
      det_data_out = 1'b1;
      cyc();
      #1;
      chk("ab_grant_clr", grant, 0);
      chk("ab_ack_clr", bit_ack, 0);
      chk("ab_match_clr", match, 0);
      chk("ab_frame_done_clr", frame_done, 0);
      chk("ab_data_in_clr", det_data_in, 0);
      chk("ab_det_reset", det_reset, 1);
      reset        = 1'b0;
      det_data_out = 1'b0;
      req          = 4'b1111;

      // All sources requesting: rotation restarts at index 0.
      run_frame(4'b0001, -1);
      run_frame(4'b0010, -1);
      run_frame(4'b0100, -1);
      run_frame(4'b1000, -1);
      run_frame(4'b0001, -1);

      // Request dropped mid-frame: frame still completes.
      req = 4'b0010;
      run_frame(4'b0010, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of serial sources sharing one sequence detector.
REQ-002 SHALL have parameter FRAME_LEN, default 16, bits streamed per grant (range 2..255).
REQ-003 SHALL have parameter DET_LAT, default 1, cycles from det_data_in sampled to corresponding det_data_out (range 1..4).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  NUM_REQ  source i has a frame ready; level.
REQ-007 SHALL have port bit_in  input  NUM_REQ  serial bit of source i.
REQ-008 SHALL have port grant  output  NUM_REQ  one-hot owner of detector; all-zero when idle.
REQ-009 SHALL have port bit_ack  output  NUM_REQ  pulse: bit_in[i] consumed this cycle; source advances its bit.
REQ-010 SHALL have port det_reset  output  1  reset to shared detector.
REQ-011 SHALL have port det_data_in  output  1  serial bit to shared detector.
REQ-012 SHALL have port det_data_out  input  1  detector match output.
REQ-013 SHALL have port match  output  NUM_REQ  one-cycle pulse: detector match attributed to source i.
REQ-014 SHALL have port frame_done  output  NUM_REQ  one-cycle pulse: frame of source i fully drained.

Function
REQ-015 SHALL implement FSM IDLE, FLUSH, STREAM, DRAIN.
REQ-016 IDLE: when any req bit set, SHALL latch round-robin winner into grant and go to FLUSH next cycle; else remain IDLE, grant=0.
REQ-017 Round-robin: search starts at index after last winner (index 0 after reset); winner = first req set, wrapping NUM_REQ-1 -> 0.
REQ-018 FLUSH: exactly one cycle, det_reset=1, then STREAM.
REQ-019 STREAM: exactly FRAME_LEN cycles; each cycle det_data_in=bit_in[owner] (registered, driven same cycle as bit_ack), bit_ack[owner]=1; 8-bit bit counter counts 0..FRAME_LEN-1, then DRAIN.
REQ-020 DRAIN: exactly DET_LAT cycles, det_data_in=0, bit_ack=0; last cycle pulses frame_done[owner]; next state IDLE; grant cleared on entry to IDLE.
REQ-021 Match routing: owner tag plus valid delayed DET_LAT cycles alongside each streamed bit; match[tag]=det_data_out only when delayed valid=1; det_data_out ignored otherwise (FLUSH, IDLE, trailing DRAIN bits beyond window).
REQ-022 req changes after grant SHALL NOT affect the current frame; frame always runs to completion.
REQ-023 Back-to-back: IDLE costs one cycle between frames; no source granted twice in a row while another requests.
REQ-024 grant, bit_ack, match, frame_done SHALL each be one-hot or zero every cycle.

Reset
REQ-025 While reset=1: state=IDLE, grant=0, bit_ack=0, match=0, frame_done=0, det_data_in=0, det_reset=1, RR pointer=NUM_REQ-1 (so index 0 searched first), delay pipeline valids cleared.
REQ-026 Reset asserted mid-STREAM/DRAIN SHALL abort the frame with no frame_done and no match pulses from in-flight bits.

Structure
REQ-027 Package seq_det_sched_pkg SHALL hold the state enum and default values of NUM_REQ, FRAME_LEN, DET_LAT.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (req, last pointer in; one-hot grant, index out).

Verification
REQ-029 Single source: req=0001, bits 1011 repeated, FRAME_LEN=16 -> grant=0001, det_reset one cycle, 16 bit_ack pulses, frame_done[0] 17+DET_LAT cycles after req.
REQ-030 All req=1111 held -> grant order 0001,0010,0100,1000,0001; no repeat while others pending.
REQ-031 Detector match at last streamed bit (DET_LAT=1) -> match[owner] pulses in DRAIN cycle, same cycle as frame_done.
REQ-032 det_data_out forced 1 during IDLE and FLUSH -> match stays 0000.
REQ-033 reset pulsed at STREAM bit 7 -> next cycle all outputs zero except det_reset=1, no frame_done; next grant goes to index 0.
REQ-034 req dropped at STREAM bit 3 -> frame still completes 16 bits and frame_done pulses.
